mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the shared 256-word LC-3 memory, which has an asynchronous read and a synchronous write. It sits between the memory array and two requesters:
- the CPU datapath port (the MAR/MDR path);
- a loader/debug port used to preload programs and inspect memory.

It grants one access at a time, drives the single memory address/write port, inserts programmable wait states, and returns read data with a one-cycle ready pulse.

## Interface
Parameters:
- WAIT_CYCLES, 0, extra access cycles per transfer (0..15).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  16  CPU word address; sampled at grant.
- cpu_wdata  in  16  CPU write data; sampled at grant.
- cpu_rdata  out  16  CPU read data.
- cpu_ready  out  1  one-cycle completion pulse.
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ready: loader port, same widths and semantics as the CPU port.
- mem_addr  out  16  address to the memory.
- mem_wdata  out  16  write data to the memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  asynchronous read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we/addr/wdata and its identity (gnt_id).
  - Load wait_cnt = WAIT_CYCLES and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values, stable for the whole state.
  - If wait_cnt != 0: decrement it and stay in ACCESS.
  - If wait_cnt == 0 (final cycle): mem_we = latched we for exactly this one cycle. For a read, capture mem_rdata into the granted port's rdata register. Go to DONE.
- DONE:
  - The granted port's ready is 1 for this single cycle; the other port's ready stays 0.
  - Go to IDLE.
- rdata registers hold their value until the next read completes on that port. A write leaves that port's rdata unchanged.
- A req still high in IDLE after ready counts as a new request, so back-to-back accesses are legal.
- Requester inputs are ignored outside IDLE.
- mem_we = 0 in IDLE and DONE.
- mem_addr and mem_wdata hold their last latched value in IDLE and DONE.
- Addresses pass through unmodified at 16 bits. The memory decodes only the low 8 bits, so addresses alias modulo 256.

## Timing
- Latency from req sampled in IDLE (cycle T) to ready high is WAIT_CYCLES+2 cycles.
  - WAIT_CYCLES=0: ACCESS in T+1, ready in T+2.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Reset values:
  - state=IDLE, wait_cnt=0, gnt_id=CPU.
  - Round-robin pointer: last=loader, so the CPU wins the first tie.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0, ld_rdata=0, cpu_ready=0, ld_ready=0.
- Reset during ACCESS before the final cycle: no write is issued, no ready pulse, and the FSM is in IDLE in the next cycle.
- Reset in DONE: the ready pulse is suppressed.
- Simultaneous requests in IDLE: resolved per the Configuration section. The loser's request stays pending and is granted in its next IDLE cycle.
- A request that drops before being granted is lost, with no side effects.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted last wins. The pointer updates at every grant.
- ARB_RR_EN undefined: fixed priority, loader over CPU. The pointer logic is absent. Under a continuous loader request the CPU starves, which is intended for program preload.

## Test plan
- Reset, WAIT_CYCLES=0, CPU write addr=0x0010 data=0xBEEF:
  - mem_we high exactly 1 cycle, in T+1, with mem_addr=0x0010.
  - cpu_ready high in T+2.
  - A following CPU read of 0x0010 returns cpu_rdata=0xBEEF at its ready.
- WAIT_CYCLES=3, loader read of 0x0020 preloaded with 0x1234: ld_ready high in T+5, ld_rdata=0x1234, and mem_addr stable 0x0020 for 4 cycles.
- Both ports request in the same IDLE cycle, held continuously, with ARB_RR_EN defined: grants alternate CPU, loader, CPU, loader. Without ARB_RR_EN, the loader is granted every time.
- reset asserted in the 2nd ACCESS cycle of a write of 0x5555 to 0x0030 (WAIT_CYCLES=3): mem_we never asserts, memory[0x30] is unchanged, no ready pulse, and all outputs return to reset values.
- Back-to-back: cpu_req held high for 3 reads with WAIT_CYCLES=0: cpu_ready pulses at T+2, T+5, T+8, and cpu_rdata holds between pulses.
- CPU write to 0x0105: memory word 0x05 is written (aliasing), and a loader read of 0x0005 returns the written value.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : CPU/loader arbiter and access sequencer for the shared memory.
//               ARB_RR_EN selects round-robin, else loader has fixed priority.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic [15:0] ld_rdata,
    output logic        ld_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic       GNT_CPU   = 1'b0;
    localparam logic       GNT_LD    = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        gnt_id_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        mem_we_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] ld_rdata_q;
    logic        cpu_ready_q;
    logic        ld_ready_q;

    logic        win_d;
    logic        any_req;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    assign any_req = cpu_req | ld_req;

`ifdef ARB_RR_EN
    logic last_q;

    always_comb begin
        win_d = GNT_CPU;
        if (cpu_req && ld_req) begin
            win_d = (last_q == GNT_LD) ? GNT_CPU : GNT_LD;
        end else if (ld_req) begin
            win_d = GNT_LD;
        end
    end
`else
    assign win_d = ld_req ? GNT_LD : GNT_CPU;
`endif

    assign sel_we    = (win_d == GNT_LD) ? ld_we    : cpu_we;
    assign sel_addr  = (win_d == GNT_LD) ? ld_addr  : cpu_addr;
    assign sel_wdata = (win_d == GNT_LD) ? ld_wdata : cpu_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            gnt_id_q    <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= 16'd0;
            ld_rdata_q  <= 16'd0;
            cpu_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
`ifdef ARB_RR_EN
            last_q      <= GNT_LD;
`endif
        end else begin
            cpu_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_id_q   <= win_d;
                        we_q       <= sel_we;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        wait_cnt_q <= WAIT_INIT;
                        // Write strobe is registered, so raise it one edge
                        // ahead of the final ACCESS cycle.
                        mem_we_q   <= sel_we && (WAIT_INIT == 4'd0);
                        state_q    <= S_ACCESS;
`ifdef ARB_RR_EN
                        last_q     <= win_d;
`endif
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                        mem_we_q   <= we_q && (wait_cnt_q == 4'd1);
                    end else begin
                        if (!we_q) begin
                            if (gnt_id_q == GNT_LD) begin
                                ld_rdata_q <= mem_rdata;
                            end else begin
                                cpu_rdata_q <= mem_rdata;
                            end
                        end
                        if (gnt_id_q == GNT_LD) begin
                            ld_ready_q <= 1'b1;
                        end else begin
                            cpu_ready_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Reset asserted during DONE must suppress the pulse in that same cycle.
    assign cpu_ready = cpu_ready_q & ~reset;
    assign ld_ready  = ld_ready_q & ~reset;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench, DUT 0 with WAIT_CYCLES=0, DUT 1 with 3.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req    [2][2];
    logic        we_s   [2][2];
    logic        rdy    [2][2];
    logic [15:0] addr_s [2][2];
    logic [15:0] wd_s   [2][2];
    logic [15:0] rd_s   [2][2];
    logic        mwe    [2];
    logic [15:0] maddr  [2];
    logic [15:0] mwd    [2];
    logic [15:0] mrd    [2];
    logic [15:0] shadow [2][2];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rst_seen = 1'b1;

    typedef struct {
        int          dut;
        int          port;
        int          cyc;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;
    typedef struct {
        int          dut;
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    acc_t aq[$];
    wr_t  wq[$];
    acc_t e;
    wr_t  w;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [256];
        assign mrd[g] = mem[maddr[g][7:0]];
        always @(posedge clk) if (mwe[g]) mem[maddr[g][7:0]] <= mwd[g];

        mem_arbiter #(.WAIT_CYCLES(g * 3)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (req[g][0]),
            .cpu_we    (we_s[g][0]),
            .cpu_addr  (addr_s[g][0]),
            .cpu_wdata (wd_s[g][0]),
            .cpu_rdata (rd_s[g][0]),
            .cpu_ready (rdy[g][0]),
            .ld_req    (req[g][1]),
            .ld_we     (we_s[g][1]),
            .ld_addr   (addr_s[g][1]),
            .ld_wdata  (wd_s[g][1]),
            .ld_rdata  (rd_s[g][1]),
            .ld_ready  (rdy[g][1]),
            .mem_addr  (maddr[g]),
            .mem_wdata (mwd[g]),
            .mem_we    (mwe[g]),
            .mem_rdata (mrd[g])
        );
    end

    function automatic int wc(int d);
        return d * 3;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Monitor: pops expected writes and completions as the DUTs present them.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_seen) begin
                shadow[d][0] = 16'd0;
                shadow[d][1] = 16'd0;
            end
            if (mwe[d]) begin
                if (wq.size() == 0 || wq[0].dut != d) begin
                    chk($sformatf("unexpected_write_dut%0d", d), {16'd0, maddr[d]}, 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", w.cyc, cyc);
                    chk("write_addr", {16'd0, maddr[d]}, {16'd0, w.addr});
                    chk("write_data", {16'd0, mwd[d]}, {16'd0, w.data});
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (rdy[d][p]) begin
                    if (aq.size() == 0 || aq[0].dut != d) begin
                        chk($sformatf("unexpected_ready_dut%0d_port%0d", d, p), 1, 0);
                    end else begin
                        e = aq.pop_front();
                        chk("ready_port", p, e.port);
                        chk("ready_cycle", cyc, e.cyc);
                        if (e.rd) shadow[d][p] = e.data;
                        chk("rdata_at_ready", {16'd0, rd_s[d][p]}, {16'd0, shadow[d][p]});
                    end
                end else begin
                    chk("rdata_hold", {16'd0, rd_s[d][p]}, {16'd0, shadow[d][p]});
                end
            end
            if (aq.size() > 0 && aq[0].dut == d && !reset) begin
                if (cyc >= aq[0].cyc - 1 - wc(d) && cyc <= aq[0].cyc - 1)
                    chk("mem_addr_stable", {16'd0, maddr[d]}, {16'd0, aq[0].addr});
            end
        end
    end

    task automatic chk_reset(int d);
        chk("rst_mem_we", {31'd0, mwe[d]}, 0);
        chk("rst_mem_addr", {16'd0, maddr[d]}, 0);
        chk("rst_mem_wdata", {16'd0, mwd[d]}, 0);
        chk("rst_cpu_rdata", {16'd0, rd_s[d][0]}, 0);
        chk("rst_ld_rdata", {16'd0, rd_s[d][1]}, 0);
        chk("rst_cpu_ready", {31'd0, rdy[d][0]}, 0);
        chk("rst_ld_ready", {31'd0, rdy[d][1]}, 0);
    endtask

    // One requester holds req for n completions; expectations are pushed up front.
    task automatic access(int d, int p, bit wr, logic [15:0] a, logic [15:0] dat, int n);
        int got = 0;
        int t = 0;
        @(posedge clk);
        #1;
        req[d][p]    = 1'b1;
        we_s[d][p]   = wr;
        addr_s[d][p] = a;
        wd_s[d][p]   = dat;
        for (int i = 0; i < n; i++) begin
            aq.push_back('{d, p, cyc + wc(d) + 2 + i * (wc(d) + 3), !wr, a, dat});
            if (wr) wq.push_back('{d, cyc + wc(d) + 1 + i * (wc(d) + 3), a, dat});
        end
        while (got < n && t < n * (wc(d) + 3) + 20) begin
            @(negedge clk);
            if (rdy[d][p]) got++;
            t++;
        end
        if (got < n) chk("access_timeout", got, n);
        req[d][p] = 1'b0;
    endtask

    initial begin
        int got;
        int t;
        int k;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p]    = 1'b0;
                we_s[d][p]   = 1'b0;
                addr_s[d][p] = 16'd0;
                wd_s[d][p]   = 16'd0;
                shadow[d][p] = 16'd0;
            end
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        // DUT 0, no wait states
        access(0, 0, 1'b1, 16'h0010, 16'hBEEF, 1);
        access(0, 0, 1'b0, 16'h0010, 16'hBEEF, 1);
        access(0, 0, 1'b0, 16'h0010, 16'hBEEF, 3);
        access(0, 0, 1'b1, 16'h0105, 16'hA5A5, 1);
        access(0, 1, 1'b0, 16'h0005, 16'hA5A5, 1);

        // Tie: both ports held; last grant was the loader
        @(posedge clk);
        #1;
        req[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 16'h0010;
        req[0][1] = 1'b1; we_s[0][1] = 1'b0; addr_s[0][1] = 16'h0005;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            if (i % 2 == 0) aq.push_back('{0, 0, cyc + 2 + 3 * i, 1'b1, 16'h0010, 16'hBEEF});
            else            aq.push_back('{0, 1, cyc + 2 + 3 * i, 1'b1, 16'h0005, 16'hA5A5});
`else
            aq.push_back('{0, 1, cyc + 2 + 3 * i, 1'b1, 16'h0005, 16'hA5A5});
`endif
        end
        got = 0;
        t = 0;
        while (got < 4 && t < 40) begin
            @(negedge clk);
            if (rdy[0][0] || rdy[0][1]) got++;
            t++;
        end
        if (got < 4) chk("tie_timeout", got, 4);
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;

        // DUT 1, three wait states
        access(1, 1, 1'b1, 16'h0020, 16'h1234, 1);
        access(1, 1, 1'b0, 16'h0020, 16'h1234, 1);
        access(1, 1, 1'b1, 16'h0030, 16'h0F0F, 1);

        // Reset in the 2nd ACCESS cycle of a CPU write; the request drops too
        @(posedge clk);
        #1;
        req[1][0] = 1'b1; we_s[1][0] = 1'b1; addr_s[1][0] = 16'h0030; wd_s[1][0] = 16'h5555;
        k = cyc;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_cycle", cyc, k + 2);
        reset = 1'b1;
        req[1][0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset(1);
        chk_reset(0);
        repeat (6) @(negedge clk);

        access(1, 1, 1'b0, 16'h0030, 16'h0F0F, 1);
        access(1, 0, 1'b0, 16'h0020, 16'h1234, 1);

        repeat (5) @(negedge clk);
        chk("queues_drained", aq.size() + wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
